// File: rtl/axi_read_arbiter_if.sv
// Bundle of requester-side ports and the AXI AR/R channel pair for axi_read_arbiter.
// The master modport is the arbiter's view; slave is the requesters' and interconnect's view.
interface axi_read_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0]  req_len;
  logic [3*NUM_REQ-1:0]  req_size;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic                  resp_last;
  logic                  resp_err;
  logic [31:0]           resp_data;
  logic                  protocol_err;

  logic [3:0]            arid;
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [3:0]            rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  req_valid, req_addr, req_len, req_size, arready,
           rid, rdata, rresp, rlast, rvalid,
    output req_ready, resp_valid, resp_last, resp_err, resp_data, protocol_err,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
           rready
  );

  modport slave (
    output req_valid, req_addr, req_len, req_size, arready,
           rid, rdata, rresp, rlast, rvalid,
    input  req_ready, resp_valid, resp_last, resp_err, resp_data, protocol_err,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
           rready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin scheduler sharing one AXI AR/R channel pair among NUM_REQ read requesters.
// ARID carries the requester index; R beats are steered back by RID with per-ID beat tracking.
module axi_read_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               resetn,
  axi_read_arbiter_if.master bus
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  typedef logic [IW-1:0] idx_t;

  logic [NUM_REQ-1:0] outstanding;
  logic [NUM_REQ-1:0] eligible;
  logic [7:0]         cnt   [NUM_REQ];
  logic [7:0]         len_q [NUM_REQ];
  idx_t               last_grant;
  idx_t               grant_idx;
  idx_t               rid_idx;
  logic               grant_vld;
  logic               slot_free;
  logic               rid_ok;
  logic               rready;
  logic               beat;
  logic               err_now;
  logic               protocol_err;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic [31:0]        sel_addr;
  logic               unused_addr_hi;
  int                 rr_idx;

  logic               arvalid;
  logic [3:0]         arid;
  logic [31:0]        araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;

  assign eligible  = bus.req_valid & ~outstanding;
  assign slot_free = !arvalid || bus.arready;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    if (slot_free) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        rr_idx = (int'(last_grant) + k) % NUM_REQ;
        if (!grant_vld && eligible[idx_t'(rr_idx)]) begin
          grant_vld = 1'b1;
          grant_idx = idx_t'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign sel_addr       = bus.req_addr[32*int'(grant_idx) +: 32];
  assign unused_addr_hi = ^sel_addr[31:29];

  assign rid_ok  = bus.rid < 4'(NUM_REQ);
  assign rid_idx = idx_t'(bus.rid);
  assign rready  = rid_ok && outstanding[rid_idx];
  assign beat    = bus.rvalid && rready;

  always_comb begin
    resp_valid = '0;
    if (beat) resp_valid[rid_idx] = 1'b1;
  end

  // A beat is well-formed only when rlast coincides with reaching the granted length.
  assign err_now = (bus.rvalid && !rready) ||
                   (beat && (bus.rlast != (cnt[rid_idx] == len_q[rid_idx])));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid      <= 1'b0;
      arid         <= '0;
      araddr       <= '0;
      arlen        <= '0;
      arsize       <= '0;
      outstanding  <= '0;
      last_grant   <= idx_t'(NUM_REQ - 1);
      protocol_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i]   <= '0;
        len_q[i] <= '0;
      end
    end else begin
      if (grant_vld) begin
        arvalid    <= 1'b1;
        arid       <= 4'(grant_idx);
        araddr     <= {3'b000, sel_addr[28:0]};
        arlen      <= bus.req_len[8*int'(grant_idx) +: 8];
        arsize     <= bus.req_size[3*int'(grant_idx) +: 3];
        last_grant <= grant_idx;
      end else if (bus.arready) begin
        arvalid <= 1'b0;
      end

      if (err_now) protocol_err <= 1'b1;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_vld && grant_idx == idx_t'(i)) begin
          outstanding[i] <= 1'b1;
          cnt[i]         <= '0;
          len_q[i]       <= bus.req_len[8*i +: 8];
        end else if (beat && rid_idx == idx_t'(i)) begin
          cnt[i] <= cnt[i] + 8'd1;
          if (bus.rlast) outstanding[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_last    = beat && bus.rlast;
  assign bus.resp_err     = beat && (bus.rresp != 2'b00);
  assign bus.resp_data    = bus.rdata;
  assign bus.protocol_err = protocol_err;
  assign bus.rready       = rready;
  assign bus.arvalid      = arvalid;
  assign bus.arid         = arid;
  assign bus.araddr       = araddr;
  assign bus.arlen        = arlen;
  assign bus.arsize       = arsize;
  assign bus.arburst      = 2'b01;
  assign bus.arlock       = 2'b00;
  assign bus.arcache      = 4'b0000;
  assign bus.arprot       = 3'b000;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant order, AR stall, R steering and protocol checks.
module tb_axi_read_arbiter;

  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  axi_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  axi_read_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    bus.req_addr[32*i +: 32] = addr;
    bus.req_len[8*i +: 8]    = len;
    bus.req_size[3*i +: 3]   = size;
  endtask

  task automatic r_beat(input int id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    bus.rid    = 4'(id);
    bus.rdata  = data;
    bus.rresp  = resp;
    bus.rlast  = last;
    bus.rvalid = 1'b1;
  endtask

  task automatic r_idle();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_size  = '0;
    bus.arready   = 1'b0;
    bus.rid       = '0;
    bus.rdata     = '0;
    bus.rresp     = '0;
    bus.rlast     = 1'b0;
    bus.rvalid    = 1'b0;

    #2;
    chk("rst_arvalid", 32'(bus.arvalid), 0);
    chk("rst_rready", 32'(bus.rready), 0);
    chk("rst_perr", 32'(bus.protocol_err), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_arid", 32'(bus.arid), 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Three requesters, back-to-back grants with arready high
    set_req(0, 32'hBFC0_0000, 8'd0, 3'd2);
    set_req(1, 32'hBFC0_0010, 8'd0, 3'd2);
    set_req(2, 32'hBFC0_0020, 8'd0, 3'd2);
    bus.req_valid = 3'b111;
    bus.arready   = 1'b1;
    #1;
    chk("g0_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("g0_arvalid", 32'(bus.arvalid), 1);
    chk("g0_arid", 32'(bus.arid), 0);
    chk("g0_araddr", bus.araddr, 32'h1FC0_0000);
    chk("g0_arburst", 32'(bus.arburst), 1);
    chk("g1_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("g1_arid", 32'(bus.arid), 1);
    chk("g1_araddr", bus.araddr, 32'h1FC0_0010);
    chk("g2_req_ready", 32'(bus.req_ready), 32'h4);
    tick();
    chk("g2_arid", 32'(bus.arid), 2);
    chk("g2_araddr", bus.araddr, 32'h1FC0_0020);
    chk("g3_req_ready_none", 32'(bus.req_ready), 0);
    bus.req_valid = 3'b000;
    tick();
    chk("drain_arvalid", 32'(bus.arvalid), 0);

    // Single-beat responses, one with SLVERR
    r_beat(2, 32'h2222_2222, 2'b10, 1'b1);
    #1;
    chk("r2_rready", 32'(bus.rready), 1);
    chk("r2_resp_valid", 32'(bus.resp_valid), 32'h4);
    chk("r2_resp_last", 32'(bus.resp_last), 1);
    chk("r2_resp_err", 32'(bus.resp_err), 1);
    chk("r2_resp_data", bus.resp_data, 32'h2222_2222);
    tick();
    r_beat(0, 32'h0000_00A0, 2'b00, 1'b1);
    #1;
    chk("r0_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("r0_resp_err", 32'(bus.resp_err), 0);
    tick();
    r_beat(1, 32'h0000_00A1, 2'b00, 1'b1);
    #1;
    chk("r1_resp_valid", 32'(bus.resp_valid), 32'h2);
    tick();
    r_idle();
    #1;
    chk("r_done_perr", 32'(bus.protocol_err), 0);
    chk("r_done_rready", 32'(bus.rready), 0);

    // AR stall: arready low for five cycles
    set_req(0, 32'h8000_1000, 8'd0, 3'd2);
    bus.req_valid = 3'b001;
    bus.arready   = 1'b0;
    #1;
    chk("st_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1, 32'h0000_2000, 8'd3, 3'd2);
    bus.req_valid = 3'b011;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("st_arvalid", 32'(bus.arvalid), 1);
      chk("st_araddr", bus.araddr, 32'h0000_1000);
      chk("st_req_ready", 32'(bus.req_ready), 0);
      tick();
    end
    bus.arready   = 1'b1;
    bus.req_valid = 3'b010;
    #1;
    chk("st_reload_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("st_reload_arvalid", 32'(bus.arvalid), 1);
    chk("st_reload_arid", 32'(bus.arid), 1);
    chk("st_reload_arlen", 32'(bus.arlen), 3);
    bus.req_valid = 3'b000;
    tick();
    chk("st_drain_arvalid", 32'(bus.arvalid), 0);

    // Interleaved R: four beats for ID 1, one for ID 0
    r_beat(1, 32'h1100_0000, 2'b00, 1'b0);
    #1;
    chk("il_b0_valid", 32'(bus.resp_valid), 32'h2);
    chk("il_b0_last", 32'(bus.resp_last), 0);
    tick();
    r_beat(0, 32'h1000_0000, 2'b00, 1'b1);
    #1;
    chk("il_id0_valid", 32'(bus.resp_valid), 32'h1);
    chk("il_id0_last", 32'(bus.resp_last), 1);
    tick();
    r_beat(1, 32'h1100_0001, 2'b00, 1'b0);
    #1;
    chk("il_b1_valid", 32'(bus.resp_valid), 32'h2);
    tick();
    r_beat(1, 32'h1100_0002, 2'b00, 1'b0);
    #1;
    chk("il_b2_valid", 32'(bus.resp_valid), 32'h2);
    chk("il_b2_last", 32'(bus.resp_last), 0);
    tick();
    r_beat(1, 32'h1100_0003, 2'b00, 1'b1);
    #1;
    chk("il_b3_valid", 32'(bus.resp_valid), 32'h2);
    chk("il_b3_last", 32'(bus.resp_last), 1);
    chk("il_b3_data", bus.resp_data, 32'h1100_0003);
    tick();
    r_idle();
    #1;
    chk("il_perr", 32'(bus.protocol_err), 0);

    // Fairness: requesters 0 and 2 held valid, last winner was 1
    set_req(0, 32'h0000_0100, 8'd0, 3'd2);
    set_req(2, 32'h0000_0200, 8'd0, 3'd2);
    bus.req_valid = 3'b101;
    #1;
    chk("rr_a", 32'(bus.req_ready), 32'h4);
    tick();
    r_beat(2, 32'h0, 2'b00, 1'b1);
    #1;
    chk("rr_b", 32'(bus.req_ready), 32'h1);
    tick();
    r_beat(0, 32'h0, 2'b00, 1'b1);
    #1;
    chk("rr_c", 32'(bus.req_ready), 32'h4);
    tick();
    r_beat(2, 32'h0, 2'b00, 1'b1);
    #1;
    chk("rr_d", 32'(bus.req_ready), 32'h1);
    tick();
    r_beat(0, 32'h0, 2'b00, 1'b1);
    #1;
    chk("rr_e", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 3'b000;
    r_beat(2, 32'h0, 2'b00, 1'b1);
    tick();
    r_idle();
    #1;
    chk("rr_perr", 32'(bus.protocol_err), 0);

    // Stray beat for an ID with nothing outstanding
    r_beat(2, 32'h0, 2'b00, 1'b1);
    #1;
    chk("pe_stray_rready", 32'(bus.rready), 0);
    chk("pe_stray_resp_valid", 32'(bus.resp_valid), 0);
    tick();
    r_idle();
    #1;
    chk("pe_stray_perr", 32'(bus.protocol_err), 1);
    tick();
    tick();
    chk("pe_sticky", 32'(bus.protocol_err), 1);

    // Asynchronous reset in the middle of a transfer
    set_req(0, 32'h0000_0300, 8'd3, 3'd2);
    bus.req_valid = 3'b001;
    bus.arready   = 1'b0;
    tick();
    bus.req_valid = 3'b000;
    bus.rid       = 4'd0;
    #1;
    chk("ar_pre_rready", 32'(bus.rready), 1);
    chk("ar_pre_arvalid", 32'(bus.arvalid), 1);
    resetn = 1'b0;
    #1;
    chk("ar_arvalid", 32'(bus.arvalid), 0);
    chk("ar_rready", 32'(bus.rready), 0);
    chk("ar_perr", 32'(bus.protocol_err), 0);
    resetn = 1'b1;
    bus.arready = 1'b1;
    tick();
    r_beat(0, 32'h0, 2'b00, 1'b1);
    #1;
    chk("ar_late_rready", 32'(bus.rready), 0);
    tick();
    r_idle();
    #1;
    chk("ar_late_perr", 32'(bus.protocol_err), 1);

    // rlast on beat 2 of a 4-beat burst
    resetn = 1'b0;
    #1 resetn = 1'b1;
    tick();
    set_req(0, 32'h0000_0400, 8'd3, 3'd2);
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid = 3'b000;
    tick();
    r_beat(0, 32'h0, 2'b00, 1'b0);
    #1;
    chk("el_b0_perr", 32'(bus.protocol_err), 0);
    tick();
    r_beat(0, 32'h0, 2'b00, 1'b1);
    #1;
    chk("el_b1_valid", 32'(bus.resp_valid), 32'h1);
    tick();
    r_idle();
    #1;
    chk("el_perr", 32'(bus.protocol_err), 1);

    // Missing rlast on the only beat of a single-beat burst
    resetn = 1'b0;
    #1 resetn = 1'b1;
    tick();
    set_req(0, 32'h0000_0500, 8'd0, 3'd2);
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid = 3'b000;
    tick();
    r_beat(0, 32'h0, 2'b00, 1'b0);
    #1;
    chk("ml_valid", 32'(bus.resp_valid), 32'h1);
    tick();
    r_idle();
    #1;
    chk("ml_perr", 32'(bus.protocol_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
